// File: rtl/csr_reg_pkg.sv
// Shared CSR definitions for the RV32I machine-mode CSR file: addresses, bit positions, funct3 encodings.
// Define CSR_CNT_HI_EN to build 64-bit mcycle/minstret with high halves at 0xB80/0xB82.
package csr_reg_pkg;

    localparam int XLEN = 32;

`ifdef CSR_CNT_HI_EN
    localparam bit CNT_HI_EN = 1'b1;
    localparam int CNT_W     = 64;
`else
    localparam bit CNT_HI_EN = 1'b0;
    localparam int CNT_W     = 32;
`endif

    localparam logic [2:0] INST_CSRRW  = 3'b001;
    localparam logic [2:0] INST_CSRRS  = 3'b010;
    localparam logic [2:0] INST_CSRRC  = 3'b011;
    localparam logic [2:0] INST_CSRRWI = 3'b101;
    localparam logic [2:0] INST_CSRRSI = 3'b110;
    localparam logic [2:0] INST_CSRRCI = 3'b111;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MIP_MSIP_BIT     = 3;
    localparam int MIP_MTIP_BIT     = 7;
    localparam int MIP_MEIP_BIT     = 11;

    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
    localparam logic [31:0] MSTATUS_MASK = 32'h0000_0088;
    localparam logic [31:0] MIE_MASK     = 32'h0000_0888;
    localparam logic [31:0] ALIGN4_MASK  = 32'hFFFF_FFFC;

    // Which agent updates mstatus in a given cycle; trap beats mret beats a plain write.
    typedef enum logic [1:0] {
        MSTATUS_SRC_NONE,
        MSTATUS_SRC_WRITE,
        MSTATUS_SRC_TRAP,
        MSTATUS_SRC_MRET
    } mstatus_src_e;

    function automatic logic csr_writable(input logic [11:0] addr);
        logic ok;
        ok = 1'b0;
        case (addr)
            CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MTVAL,
            CSR_MCYCLE, CSR_MINSTRET:          ok = 1'b1;
            CSR_MCYCLEH, CSR_MINSTRETH:        ok = CNT_HI_EN;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Value a read would return right after this write commits, used for write-first bypass.
    function automatic logic [31:0] csr_write_view(input logic [11:0] addr, input logic [31:0] wdata);
        logic [31:0] v;
        v = wdata;
        case (addr)
            CSR_MSTATUS:          v = (wdata & MSTATUS_MASK) | MSTATUS_MPP;
            CSR_MIE:              v = wdata & MIE_MASK;
            CSR_MTVEC, CSR_MEPC:  v = wdata & ALIGN4_MASK;
            default:              v = wdata;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/csr_reg_if.sv
// CSR read/write port shared by the decode (read) and execute (write) stages.
interface csr_reg_if;
    import csr_reg_pkg::*;

    logic [XLEN-1:0] raddr_i;
    logic [XLEN-1:0] rdata_o;
    logic            we_i;
    logic [XLEN-1:0] waddr_i;
    logic [XLEN-1:0] wdata_i;

    modport master (
        output raddr_i,
        output we_i,
        output waddr_i,
        output wdata_i,
        input  rdata_o
    );

    modport slave (
        input  raddr_i,
        input  we_i,
        input  waddr_i,
        input  wdata_i,
        output rdata_o
    );

endinterface

// File: rtl/csr_counter.sv
// Free-running 32/64-bit CSR counter with increment enable and a 32-bit load port per half.
// A load of either half suppresses that cycle's increment; high-half loads are ignored when WIDTH is 32.
module csr_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic             we,
    input  logic             wsel_hi,
    input  logic [31:0]      wdata,
    output logic [WIDTH-1:0] value
);

    localparam bit             HAS_HI  = (WIDTH > 32);
    localparam logic [WIDTH-1:0] LO_MASK = WIDTH'(32'hFFFF_FFFF);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] wide_wdata;
    logic             load;

    assign wide_wdata = {(WIDTH/32){wdata}};
    assign load       = we && (HAS_HI || !wsel_hi);

    // Replicating wdata across both halves lets one mask pick the target half for either width.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (wsel_hi) begin
                cnt_d = (cnt_q & LO_MASK) | (wide_wdata & ~LO_MASK);
            end else begin
                cnt_d = (cnt_q & ~LO_MASK) | (wide_wdata & LO_MASK);
            end
        end else if (inc_en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value = cnt_q;

endmodule

// File: rtl/csr_reg.sv
// Machine-mode CSR file: combinational read with write-first bypass, trap/mret/write commit on the clock edge.
// Define CSR_CNT_HI_EN for 64-bit mcycle/minstret (high halves at 0xB80/0xB82, RO aliases 0xC80/0xC82).
module csr_reg
    import csr_reg_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    csr_reg_if.slave        bus,
    input  logic            instret_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic [XLEN-1:0] trap_val_i,
    input  logic            mret_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            irq_take_o
);

    logic [11:0] raddr;
    logic [11:0] waddr;
    logic        unused_addr_bits;

    assign raddr            = bus.raddr_i[11:0];
    assign waddr            = bus.waddr_i[11:0];
    assign unused_addr_bits = ^{bus.raddr_i[31:12], bus.waddr_i[31:12]};

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause, wr_mtval;
    logic wr_cycle, wr_instret;

    assign wr_mstatus  = bus.we_i && (waddr == CSR_MSTATUS);
    assign wr_mie      = bus.we_i && (waddr == CSR_MIE);
    assign wr_mtvec    = bus.we_i && (waddr == CSR_MTVEC);
    assign wr_mscratch = bus.we_i && (waddr == CSR_MSCRATCH);
    assign wr_mepc     = bus.we_i && (waddr == CSR_MEPC);
    assign wr_mcause   = bus.we_i && (waddr == CSR_MCAUSE);
    assign wr_mtval    = bus.we_i && (waddr == CSR_MTVAL);
    assign wr_cycle    = bus.we_i && ((waddr == CSR_MCYCLE)   || (waddr == CSR_MCYCLEH));
    assign wr_instret  = bus.we_i && ((waddr == CSR_MINSTRET) || (waddr == CSR_MINSTRETH));

    logic        mstatus_mie, mstatus_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q;
    logic [31:0] mip_d;
    mstatus_src_e mstatus_src;

    always_comb begin
        mstatus_src = MSTATUS_SRC_NONE;
        if (trap_i) begin
            mstatus_src = MSTATUS_SRC_TRAP;
        end else if (mret_i) begin
            mstatus_src = MSTATUS_SRC_MRET;
        end else if (wr_mstatus) begin
            mstatus_src = MSTATUS_SRC_WRITE;
        end
    end

    always_comb begin
        mip_d               = '0;
        mip_d[MIP_MSIP_BIT] = irq_sw_i;
        mip_d[MIP_MTIP_BIT] = irq_timer_i;
        mip_d[MIP_MEIP_BIT] = irq_ext_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else begin
            case (mstatus_src)
                MSTATUS_SRC_TRAP: begin
                    mstatus_mpie <= mstatus_mie;
                    mstatus_mie  <= 1'b0;
                end
                MSTATUS_SRC_MRET: begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end
                MSTATUS_SRC_WRITE: begin
                    mstatus_mie  <= bus.wdata_i[MSTATUS_MIE_BIT];
                    mstatus_mpie <= bus.wdata_i[MSTATUS_MPIE_BIT];
                end
                default: begin
                    mstatus_mie  <= mstatus_mie;
                    mstatus_mpie <= mstatus_mpie;
                end
            endcase
        end
    end

    // Trap entry owns mepc/mcause/mtval; a coincident write to any other CSR still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mip_q      <= '0;
        end else begin
            mip_q <= mip_d;
            if (wr_mie)      mie_q      <= bus.wdata_i & MIE_MASK;
            if (wr_mtvec)    mtvec_q    <= bus.wdata_i & ALIGN4_MASK;
            if (wr_mscratch) mscratch_q <= bus.wdata_i;
            if (trap_i) begin
                mepc_q   <= trap_pc_i & ALIGN4_MASK;
                mcause_q <= trap_cause_i;
                mtval_q  <= trap_val_i;
            end else begin
                if (wr_mepc)   mepc_q   <= bus.wdata_i & ALIGN4_MASK;
                if (wr_mcause) mcause_q <= bus.wdata_i;
                if (wr_mtval)  mtval_q  <= bus.wdata_i;
            end
        end
    end

    logic [CNT_W-1:0] mcycle;
    logic [CNT_W-1:0] minstret;

    csr_counter #(.WIDTH(CNT_W)) u_mcycle (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (1'b1),
        .we      (wr_cycle),
        .wsel_hi (waddr == CSR_MCYCLEH),
        .wdata   (bus.wdata_i),
        .value   (mcycle)
    );

    csr_counter #(.WIDTH(CNT_W)) u_minstret (
        .clk     (clk),
        .rst     (rst),
        .inc_en  (instret_i),
        .we      (wr_instret),
        .wsel_hi (waddr == CSR_MINSTRETH),
        .wdata   (bus.wdata_i),
        .value   (minstret)
    );

    logic [31:0] mstatus_rd;
    logic [31:0] state_rd;

    always_comb begin
        mstatus_rd                   = MSTATUS_MPP;
        mstatus_rd[MSTATUS_MIE_BIT]  = mstatus_mie;
        mstatus_rd[MSTATUS_MPIE_BIT] = mstatus_mpie;
    end

    // Unimplemented addresses, including disabled counter high halves, fall through to zero.
    always_comb begin
        state_rd = '0;
        case (raddr)
            CSR_MSTATUS:              state_rd = mstatus_rd;
            CSR_MISA:                 state_rd = MISA_VALUE;
            CSR_MIE:                  state_rd = mie_q;
            CSR_MTVEC:                state_rd = mtvec_q;
            CSR_MSCRATCH:             state_rd = mscratch_q;
            CSR_MEPC:                 state_rd = mepc_q;
            CSR_MCAUSE:               state_rd = mcause_q;
            CSR_MTVAL:                state_rd = mtval_q;
            CSR_MIP:                  state_rd = mip_q;
            CSR_MCYCLE, CSR_CYCLE:    state_rd = mcycle[31:0];
            CSR_MINSTRET, CSR_INSTRET: state_rd = minstret[31:0];
`ifdef CSR_CNT_HI_EN
            CSR_MCYCLEH, CSR_CYCLEH:     state_rd = mcycle[63:32];
            CSR_MINSTRETH, CSR_INSTRETH: state_rd = minstret[63:32];
`endif
            CSR_MHARTID:              state_rd = HART_ID;
            default:                  state_rd = '0;
        endcase
    end

    always_comb begin
        bus.rdata_o = state_rd;
        if (bus.we_i && (waddr == raddr) && csr_writable(waddr)) begin
            bus.rdata_o = csr_write_view(waddr, bus.wdata_i);
        end
    end

    assign mtvec_o    = mtvec_q;
    assign mepc_o     = mepc_q;
    assign irq_take_o = mstatus_mie & (|(mie_q & mip_q));

endmodule

// File: tb/tb_csr_reg.sv
// Directed self-checking bench for csr_reg: table of single-cycle read/write vectors plus trap, counter and reset sequences.
module tb_csr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        instret_i, trap_i, mret_i;
    logic        irq_sw_i, irq_timer_i, irq_ext_i;
    logic [31:0] trap_pc_i, trap_cause_i, trap_val_i;
    logic [31:0] mtvec_o, mepc_o;
    logic        irq_take_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    csr_reg_if bus ();

    csr_reg #(.HART_ID(32'h5), .MTVEC_RESET(32'h100)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .instret_i    (instret_i),
        .trap_i       (trap_i),
        .trap_pc_i    (trap_pc_i),
        .trap_cause_i (trap_cause_i),
        .trap_val_i   (trap_val_i),
        .mret_i       (mret_i),
        .irq_sw_i     (irq_sw_i),
        .irq_timer_i  (irq_timer_i),
        .irq_ext_i    (irq_ext_i),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .irq_take_o   (irq_take_o)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(logic we, logic [31:0] waddr, logic [31:0] wdata,
                                   logic [31:0] raddr, logic [31:0] exp_rdata);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] waddr,
                                 input logic [31:0] wdata, input logic [31:0] raddr);
        bus.we_i    = we;
        bus.waddr_i = waddr;
        bus.wdata_i = wdata;
        bus.raddr_i = raddr;
    endtask

    task automatic clearStrobes();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        instret_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
        trap_pc_i = '0; trap_cause_i = '0; trap_val_i = '0;
        irq_sw_i = 1'b0; irq_timer_i = 1'b0; irq_ext_i = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; checks sample 1 unit later still.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string name, input logic [31:0] raddr, input logic [31:0] expected);
        bus.raddr_i = raddr;
        #1;
        checkOutput(name, bus.rdata_o, expected);
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearStrobes();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        clearStrobes();
        doReset();

        checkOutput("rst_mtvec_o", mtvec_o, 32'h100);
        checkOutput("rst_mepc_o", mepc_o, 32'h0);
        checkOutput("rst_irq_take", {31'b0, irq_take_o}, 32'h0);
        readCheck("rst_mcycle_zero", 32'hB00, 32'h0);
        step();
        readCheck("mcycle_first_inc", 32'hB00, 32'h1);

        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h305,       32'h100));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h300,       32'h1800));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h301,       32'h4000_0100));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'hF14,       32'h5));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h344,       32'h0));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h123,       32'h0));
        vecs.push_back(mkVec(1'b1, 32'h340, 32'hDEAD_BEEF, 32'h340,       32'hDEAD_BEEF));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h340,       32'hDEAD_BEEF));
        vecs.push_back(mkVec(1'b1, 32'h300, 32'hFFFF_FFFF, 32'h300,       32'h1888));
        vecs.push_back(mkVec(1'b1, 32'h304, 32'hFFFF_FFFF, 32'h300,       32'h1888));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h304,       32'h888));
        vecs.push_back(mkVec(1'b1, 32'h305, 32'h203,       32'h305,       32'h200));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'hFFFF_F305, 32'h200));
        vecs.push_back(mkVec(1'b1, 32'h341, 32'h7F,        32'h342,       32'h0));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h341,       32'h7C));
        vecs.push_back(mkVec(1'b1, 32'h301, 32'h0,         32'h301,       32'h4000_0100));
        vecs.push_back(mkVec(1'b1, 32'h344, 32'hFFFF_FFFF, 32'h344,       32'h0));
        vecs.push_back(mkVec(1'b1, 32'h7C0, 32'h55,        32'h7C0,       32'h0));
        vecs.push_back(mkVec(1'b1, 32'h343, 32'hABC,       32'h343,       32'hABC));
        vecs.push_back(mkVec(1'b1, 32'h300, 32'h0,         32'h300,       32'h1800));
        vecs.push_back(mkVec(1'b0, 32'h0,   32'h0,         32'h300,       32'h1800));
`ifdef CSR_CNT_HI_EN
        vecs.push_back(mkVec(1'b1, 32'hB80, 32'h77,        32'hB80,       32'h77));
`else
        vecs.push_back(mkVec(1'b1, 32'hB80, 32'h77,        32'hB80,       32'h0));
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].raddr);
            #1;
            checkOutput($sformatf("vec%0d_rdata", i), bus.rdata_o, vecs[i].exp_rdata);
            step();
        end
        clearStrobes();
        #1;
        checkOutput("tbl_mtvec_o", mtvec_o, 32'h200);
        checkOutput("tbl_mepc_o", mepc_o, 32'h7C);

        // Interrupt enable, trap entry and mret.
        applyStimulus(1'b1, 32'h300, 32'h8, 32'h300);
        step();
        applyStimulus(1'b1, 32'h304, 32'h80, 32'h304);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h300);
        irq_timer_i = 1'b1;
        #1;
        checkOutput("irq_not_yet", {31'b0, irq_take_o}, 32'h0);
        step();
        #1;
        checkOutput("irq_take", {31'b0, irq_take_o}, 32'h1);
        readCheck("mip_timer", 32'h344, 32'h80);
        trap_i = 1'b1; trap_pc_i = 32'h44; trap_cause_i = 32'h8000_0007; trap_val_i = 32'h0;
        step();
        trap_i = 1'b0;
        readCheck("trap_mstatus", 32'h300, 32'h1880);
        checkOutput("trap_mepc_o", mepc_o, 32'h44);
        checkOutput("trap_irq_masked", {31'b0, irq_take_o}, 32'h0);
        readCheck("trap_mcause", 32'h342, 32'h8000_0007);
        mret_i = 1'b1;
        applyStimulus(1'b1, 32'h300, 32'h0, 32'h300);
        step();
        mret_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h300);
        readCheck("mret_mstatus", 32'h300, 32'h1888);
        checkOutput("mret_irq_take", {31'b0, irq_take_o}, 32'h1);
        irq_timer_i = 1'b0;
        step();
        #1;
        checkOutput("irq_drop", {31'b0, irq_take_o}, 32'h0);

        // Trap beats a write to mepc; a write to an unrelated CSR still commits.
        trap_i = 1'b1; trap_pc_i = 32'h88;
        applyStimulus(1'b1, 32'h341, 32'h200, 32'h0);
        step();
        trap_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        readCheck("trap_vs_we_mepc", 32'h341, 32'h88);
        trap_i = 1'b1; trap_pc_i = 32'h90;
        applyStimulus(1'b1, 32'h340, 32'h1234, 32'h0);
        step();
        trap_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        readCheck("trap_with_mscratch", 32'h340, 32'h1234);
        checkOutput("trap2_mepc_o", mepc_o, 32'h90);

        // mcycle wrap.
        doReset();
        applyStimulus(1'b1, 32'hB00, 32'hFFFF_FFFE, 32'hB00);
        #1;
        checkOutput("mcycle_bypass", bus.rdata_o, 32'hFFFF_FFFE);
        step();
        applyStimulus(1'b0, 32'h0, 32'h0, 32'hB00);
        readCheck("mcycle_loaded", 32'hB00, 32'hFFFF_FFFE);
        step();
        readCheck("mcycle_max", 32'hC00, 32'hFFFF_FFFF);
        step();
        readCheck("mcycle_wrap", 32'hB00, 32'h0);
`ifdef CSR_CNT_HI_EN
        readCheck("mcycleh_carry", 32'hB80, 32'h1);
`else
        readCheck("mcycleh_absent", 32'hB80, 32'h0);
`endif

        // minstret: five retire pulses, write lands in the third.
        doReset();
        for (int k = 1; k <= 5; k++) begin
            instret_i = 1'b1;
            if (k == 3) begin
                applyStimulus(1'b1, 32'hB02, 32'h1000, 32'hB02);
                #1;
                checkOutput("minstret_bypass", bus.rdata_o, 32'h1000);
            end else begin
                applyStimulus(1'b0, 32'h0, 32'h0, 32'hB02);
            end
            step();
        end
        instret_i = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
        readCheck("minstret_final", 32'hB02, 32'h1002);
        readCheck("instret_alias", 32'hC02, 32'h1002);

        // Reset asserted while a trap is being presented.
        trap_i = 1'b1; trap_pc_i = 32'h99C; trap_cause_i = 32'h2;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_mtvec_o", mtvec_o, 32'h100);
        step();
        trap_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_trap_mepc_o", mepc_o, 32'h0);
        readCheck("rst_trap_mcause", 32'h342, 32'h0);
        readCheck("rst_trap_mstatus", 32'h300, 32'h1800);
        readCheck("rst_trap_mcycle", 32'hB00, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_reg.md
# csr_reg

Machine-mode CSR file of the RV32I core: answers the combinational CSR read issued by `id` in decode and commits CSR writes from `ex`, trap entry and `mret` on the clock edge. It holds the trap-handling registers plus free-running `mcycle`/`minstret` counters. It feeds the trap vector, return address and interrupt enables to the interrupt/flush logic.

## Interface
- HART_ID, 0, value returned by `mhartid` (0xF14)
- MTVEC_RESET, 32'h0, reset value of `mtvec`
- clk  in  1  core clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- raddr_i  in  `MemAddrBus`  CSR read address from `id`; only bits [11:0] decoded
- rdata_o  out  `RegBus`  read data, combinational
- we_i  in  1  CSR write strobe from `ex`
- waddr_i  in  `MemAddrBus`  write address; bits [11:0] decoded
- wdata_i  in  `RegBus`  final write value (`ex` has already applied RW/RS/RC)
- instret_i  in  1  one instruction retired this cycle
- trap_i  in  1  trap entry strobe
- trap_pc_i  in  `InstAddrBus`  PC saved to `mepc`
- trap_cause_i  in  `RegBus`  value saved to `mcause`
- trap_val_i  in  `RegBus`  value saved to `mtval`
- mret_i  in  1  `mret` executed
- irq_sw_i, irq_timer_i, irq_ext_i  in  1 each  raw interrupt lines
- mtvec_o  out  `RegBus`  current `mtvec`
- mepc_o  out  `RegBus`  current `mepc`
- irq_take_o  out  1  `mstatus.MIE & |(mie & mip)`

## Operation
- Registers: mstatus 0x300, misa 0x301 (RO, 32'h4000_0100), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344 (RO), mcycle 0xB00, minstret 0xB02, cycle/instret 0xC00/0xC02 (RO aliases), mhartid 0xF14.
- Write masks: mstatus writable bits MIE[3], MPIE[7]; MPP[12:11] reads 2'b11; other bits read 0. mie writable bits 3/7/11 only. mtvec[1:0] and mepc[1:0] forced 0. Writes to RO or unimplemented addresses are ignored; reads of unimplemented addresses return 0.
- mip: bits 3/7/11 = irq_sw/timer/ext, each registered once (one-cycle latency).
- Read bypass: if `we_i` and waddr_i[11:0]==raddr_i[11:0] and target is writable, rdata_o = masked wdata_i (write-first); counters bypass likewise.
- Trap entry: mepc<=trap_pc_i, mcause<=trap_cause_i, mtval<=trap_val_i, MPIE<=MIE, MIE<=0.
- mret: MIE<=MPIE, MPIE<=1.
- Priority per register, same cycle: trap_i > mret_i > we_i. A we_i to a register not touched by the winner still commits.
- mcycle +1 every cycle; minstret +1 when instret_i. A we_i to a counter loads wdata_i that cycle; the increment is dropped for that cycle. Counters wrap 0xFFFF_FFFF -> 0 silently.

## Timing
- Reads: zero latency, combinational from raddr_i, state and write bypass.
- Writes/trap/mret: visible in state and outputs the cycle after the strobe.
- Reset: every register is 0 except mtvec=MTVEC_RESET and MPP=2'b11. mtvec_o=MTVEC_RESET, mepc_o=0, irq_take_o=0; counters restart at 0 on release. Reset asserted mid-trap discards the trap.
- irq_take_o: combinational from registered state, so interrupt lines reach it after 1 cycle.

## Configuration
- CSR_CNT_HI_EN defined: mcycle/minstret are 64-bit. High halves are at 0xB80/0xB82, with RO aliases 0xC80/0xC82, and carry from the low half. A write to a low half leaves the high half unchanged, and the reverse also holds.
- Not defined: counters are 32-bit, high-half addresses read 0, and writes to them are ignored.

## Structure
- CSR address constants, mstatus/mip bit positions and the misa value go in the shared defines file, next to the `INST_CSRR*` encodings.
- Sub-module `csr_counter`: parameterised 32/64-bit counter with increment enable, load port and low/high write select. It is instantiated twice.

## Test plan
- Reset then read 0x305 with MTVEC_RESET=32'h100 -> rdata_o=32'h100; read 0x300 -> 32'h1800.
- Write mscratch 32'hDEAD_BEEF with raddr_i=0x340 in the same cycle -> rdata_o=32'hDEAD_BEEF that cycle (bypass) and the value stays on later reads.
- mstatus.MIE=1, mie=32'h80, raise irq_timer_i -> irq_take_o=1 one cycle later. Then trap_i with trap_pc_i=32'h44 -> mepc=32'h44, MIE=0, MPIE=1, irq_take_o=0. Then mret_i -> MIE=1.
- trap_i and we_i to mepc (32'h200) in the same cycle -> mepc=trap_pc_i; a simultaneous we_i to mscratch still commits.
- Write mcycle=32'hFFFF_FFFE, then idle 2 cycles -> reads 32'hFFFF_FFFF, then 0. With CSR_CNT_HI_EN, mcycleh increments by 1 on that wrap.
- Pulse instret_i 5 cycles with a minstret write in the 3rd -> final minstret = written value + 2.
